// File: rtl/collatz_pkg.sv
// ----------------------------------------------------------------------
// collatz_pkg : shared types and constants for the collatz cores
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package collatz_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DIV    = 2'd1;
  localparam state_t COMMIT = 2'd2;

  localparam logic DIR_DOUBLE = 1'b0;
  localparam logic DIR_ODD    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/div3_serial.sv
// ----------------------------------------------------------------------
// div3_serial : restoring divide-by-3, one quotient bit per cycle, MSB first
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module div3_serial
  import collatz_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic [1:0]       rem,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_quot;
  logic [1:0]       r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_trial;
  logic       w_qbit;
  logic [1:0] w_rem_next;

  // Partial remainder is at most 2, so the trial value never exceeds 5.
  always_comb begin
    w_trial = {r_rem, r_shift[WIDTH-1]};
    w_qbit  = (w_trial >= 3'd3);
    case (w_trial)
      3'd3:    w_rem_next = 2'd0;
      3'd4:    w_rem_next = 2'd1;
      3'd5:    w_rem_next = 2'd2;
      default: w_rem_next = w_trial[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_quot  <= '0;
      r_rem   <= 2'd0;
      r_cnt   <= '0;
    end else if (start) begin
      r_shift <= dividend;
      r_quot  <= '0;
      r_rem   <= 2'd0;
      r_cnt   <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      r_quot  <= {r_quot[WIDTH-2:0], w_qbit};
      r_rem   <= w_rem_next;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // done marks the cycle whose rising edge retires the last quotient bit.
  assign done     = (r_cnt == CNT_W'(1));
  assign quotient = r_quot;
  assign rem      = r_rem;

endmodule

`default_nettype wire

// File: rtl/collatz_inverse.sv
// ----------------------------------------------------------------------
// collatz_inverse : reverse Collatz tree walker with nibble-serial output
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module collatz_inverse
  import collatz_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_valid,
  input  logic               dir,
  output logic               ready,
  output logic               rej,
  output logic               ovf,
  output logic [DEPTH_W-1:0] depth,
  output logic               frame,
  output logic [3:0]         out
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);

  state_t             r_state;
  logic [WIDTH-1:0]   r_value;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_rej;
  logic [IDX_W-1:0]   r_idx;

  logic               w_accept;
  logic               w_div_start;
  logic               w_legal;
  logic [DEPTH_W-1:0] w_depth_inc;
  logic [WIDTH-1:0]   div_quot;
  logic [1:0]         div_rem;
  logic               div_done;

  assign w_accept    = step_valid && (r_state == IDLE);
  assign w_div_start = w_accept && (dir == DIR_ODD);
  assign w_legal     = (div_rem == 2'd0) && div_quot[0] && (div_quot > WIDTH'(1));
  assign w_depth_inc = (r_depth == '1) ? r_depth : r_depth + 1'b1;

  // value >= 1 always, so value-1 never wraps.
  div3_serial #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (r_value - WIDTH'(1)),
    .quotient (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_value <= WIDTH'(1);
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_rej <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (dir == DIR_DOUBLE) begin
              if (r_value[WIDTH-1]) begin
                r_ovf <= 1'b1;
              end else begin
                r_value <= {r_value[WIDTH-2:0], 1'b0};
                r_depth <= w_depth_inc;
              end
            end else begin
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) r_state <= COMMIT;
        end
        COMMIT: begin
          if (w_legal) begin
            r_value <= div_quot;
            r_depth <= w_depth_inc;
          end else begin
            r_rej <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Scan index free-runs regardless of FSM activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (r_idx == IDX_W'(NIBBLES - 1)) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign ready = (r_state == IDLE);
  assign rej   = r_rej;
  assign ovf   = r_ovf;
  assign depth = r_depth;
  assign frame = (r_idx == '0);
  assign out   = r_value[{r_idx, 2'b00} +: 4];

endmodule

`default_nettype wire

// File: tb/tb_collatz_inverse.sv
// ----------------------------------------------------------------------
// tb_collatz_inverse : randomized self-checking bench with arithmetic model
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_collatz_inverse;
  import collatz_pkg::*;

  localparam int W   = DEFAULT_WIDTH;
  localparam int DW  = 8;
  localparam int NIB = W / 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          step_valid;
  logic          dir;
  logic          ready;
  logic          rej;
  logic          ovf;
  logic [DW-1:0] depth;
  logic          frame;
  logic [3:0]    out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: plain integers following the walk rules.
  int m_value;
  int m_depth;
  int m_ovf;

  collatz_inverse #(
    .WIDTH   (W),
    .DEPTH_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_valid (step_valid),
    .dir        (dir),
    .ready      (ready),
    .rej        (rej),
    .ovf        (ovf),
    .depth      (depth),
    .frame      (frame),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_value = 1;
    m_depth = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit d, output bit exp_rej);
    int m;
    int q;
    exp_rej = 1'b0;
    if (d == 1'b0) begin
      if (m_value >= (1 << (W - 1))) m_ovf = 1;
      else begin
        m_value = m_value * 2;
        if (m_depth < (1 << DW) - 1) m_depth++;
      end
    end else begin
      m = m_value - 1;
      q = m / 3;
      if ((m % 3 == 0) && (q % 2 == 1) && (q > 1)) begin
        m_value = q;
        if (m_depth < (1 << DW) - 1) m_depth++;
      end else begin
        exp_rej = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    step_valid = 1'b0;
    dir = 1'b0;
    #1;
    check("rst_out", out, 4'h1);
    check("rst_frame", frame, 1);
    check("rst_ready", ready, 1);
    check("rst_depth", depth, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rej", rej, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_out", out, 4'h1);
    check("rel_frame", frame, 1);
    model_reset();
  endtask

  // Gathers one full nibble frame from the serial output.
  task automatic read_value(output int v);
    int t;
    v = 0;
    t = 0;
    @(negedge clk);
    while (!frame && t < 4 * NIB) begin
      @(negedge clk);
      t++;
    end
    check("frame_seen", frame, 1);
    for (int i = 0; i < NIB; i++) begin
      if (i > 0) @(negedge clk);
      if (i > 0) check("frame_low", frame, 0);
      v = v | (int'(out) << (4 * i));
    end
  endtask

  task automatic step(input bit d, input bit check_val);
    bit er;
    int t;
    int busy;
    int v;
    @(negedge clk);
    t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", ready, 1);
    step_valid = 1'b1;
    dir = d;
    model_step(d, er);
    @(negedge clk);
    step_valid = 1'b0;
    dir = 1'($urandom_range(0, 1));
    if (d == 1'b0) begin
      check("dbl_ready", ready, 1);
      check("dbl_rej", rej, 0);
    end else begin
      busy = 0;
      while (!ready && busy < 100) begin
        busy++;
        step_valid = ($urandom_range(0, 1) == 1);
        dir = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      step_valid = 1'b0;
      check("odd_busy", busy, W + 1);
      check("odd_rej", rej, er);
      @(negedge clk);
      check("rej_pulse", rej, 0);
    end
    check("ovf", ovf, m_ovf);
    check("depth", depth, m_depth);
    if (check_val) begin
      read_value(v);
      check("value", v, m_value);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int n;
    int fwd[$];
    int exp_nib[4];
    rst_n = 1'b0;
    step_valid = 1'b0;
    dir = 1'b0;
    exp_nib = '{4, 3, 2, 1};

    // Four doubles, then the legal odd branch 16 -> 5.
    do_reset();
    repeat (4) step(DIR_DOUBLE, 1'b0);
    read_value(v);
    check("val16", v, 32'h10);
    step(DIR_ODD, 1'b1);
    check("val5_depth", depth, 5);

    // Illegal odd branches from 8 (remainder) and from 4 (quotient 1).
    do_reset();
    repeat (3) step(DIR_DOUBLE, 1'b0);
    step(DIR_ODD, 1'b1);
    do_reset();
    repeat (2) step(DIR_DOUBLE, 1'b0);
    step(DIR_ODD, 1'b1);

    // Overflow at the top bit; flag stays sticky across later steps.
    do_reset();
    repeat (15) step(DIR_DOUBLE, 1'b0);
    read_value(v);
    check("val8000", v, 32'h8000);
    step(DIR_DOUBLE, 1'b1);
    check("ovf_set", ovf, 1);
    step(DIR_ODD, 1'b1);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    step_valid = 1'b1;
    dir = DIR_ODD;
    @(negedge clk);
    step_valid = 1'b0;
    repeat (6) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_ready", ready, 1);
    check("mid_depth", depth, 0);
    check("mid_ovf", ovf, 0);
    check("mid_out", out, 4'h1);
    check("mid_frame", frame, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(DIR_DOUBLE, 1'b1);

    // Reverse walk to 0x1234 derived from its forward trajectory.
    do_reset();
    n = 32'h1234;
    fwd.push_back(n);
    while (n != 1) begin
      n = (n % 2 == 0) ? n / 2 : 3 * n + 1;
      fwd.push_back(n);
    end
    for (int i = fwd.size() - 1; i > 0; i--) begin
      step((fwd[i-1] == 2 * fwd[i]) ? DIR_DOUBLE : DIR_ODD, 1'b0);
    end
    @(negedge clk);
    n = 0;
    while (!frame && n < 4 * NIB) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 2 * NIB; i++) begin
      check("scan_nib", out, exp_nib[i % 4]);
      check("scan_frame", frame, (i % 4) == 0);
      @(negedge clk);
    end

    // Randomized walk, biased toward doubling.
    do_reset();
    repeat (40) step(($urandom_range(0, 9) < 6) ? DIR_DOUBLE : DIR_ODD, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
